// File: rtl/pcu_pkg.sv
// rtl/pcu_pkg.sv - shared PCU command, offset and state definitions
// Purpose: types and constants shared by the PCU sampler master and the PCU tests.
// Contents: op enum, word offsets, section stride, FSM state enum, read step enum,
//           and pcu_addr() to form a PCU word address from a section and an offset.
package pcu_pkg;

    typedef enum logic [1:0] {
        OP_STOP      = 2'd0,
        OP_GO        = 2'd1,
        OP_SAMPLE    = 2'd2,
        OP_CLEAR_ALL = 2'd3
    } pcu_op_e;

    localparam logic [1:0] OFF_LO = 2'd0;  // also the stop register on write
    localparam logic [1:0] OFF_HI = 2'd1;  // also the go register on write
    localparam logic [1:0] OFF_EV = 2'd2;

    localparam int SECTION_STRIDE = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_CHECK   = 3'd4,
        ST_RESP    = 3'd5
    } pcu_state_e;

    // Which word of the SAMPLE sequence the outstanding read belongs to.
    typedef enum logic [1:0] {
        RS_HI1 = 2'd0,
        RS_LO  = 2'd1,
        RS_EV  = 2'd2,
        RS_HI2 = 2'd3
    } pcu_rd_step_e;

    function automatic logic [3:0] pcu_addr(input logic [1:0] section, input logic [1:0] off);
        return 4'(int'(section) * SECTION_STRIDE + int'(off));
    endfunction

endpackage

// File: rtl/pcu_sampler_master.sv
// rtl/pcu_sampler_master.sv - Avalon-MM master driving the PCU control slave
// Purpose: turns STOP/GO/SAMPLE/CLEAR_ALL commands into PCU accesses; SAMPLE returns a
//          tear-free 64-bit time count and a 32-bit event count.
// Ports: clk, reset_n (async, active low)
//        cmd_valid/cmd_ready/cmd_op/cmd_section        command input
//        avm_address/read/write/writedata/waitrequest,
//        avm_readdata/readdatavalid                    Avalon-MM master to the PCU
//        rsp_valid/rsp_ready/rsp_section/rsp_time,
//        rsp_events/rsp_torn/rsp_err                   SAMPLE response
//        busy                                          FSM not idle
module pcu_sampler_master
    import pcu_pkg::*;
#(
    parameter int MAX_RETRY  = 3,
    parameter int RD_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [1:0]  cmd_section,
    output logic [3:0]  avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_section,
    output logic [63:0] rsp_time,
    output logic [31:0] rsp_events,
    output logic        rsp_torn,
    output logic        rsp_err,
    output logic        busy
);

    localparam int RW = ($clog2(MAX_RETRY + 1) < 2) ? 2 : $clog2(MAX_RETRY + 1);
    localparam int TW = (RD_TIMEOUT < 1) ? 1 : $clog2(RD_TIMEOUT + 1);

    pcu_state_e   state_q;
    pcu_rd_step_e step_q;
    logic [1:0]   sect_q;
    logic [RW-1:0] retry_q;
    logic [TW-1:0] tmo_q;
    logic [31:0]  hi1_q, hi2_q, lo_q, ev_q;

    logic [3:0]   avm_address_q;
    logic         avm_read_q, avm_write_q;
    logic [31:0]  avm_writedata_q;
    logic         rsp_valid_q, rsp_torn_q, rsp_err_q;
    logic [1:0]   rsp_section_q;
    logic [63:0]  rsp_time_q;
    logic [31:0]  rsp_events_q;

    assign avm_address   = avm_address_q;
    assign avm_read      = avm_read_q;
    assign avm_write     = avm_write_q;
    assign avm_writedata = avm_writedata_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_section   = rsp_section_q;
    assign rsp_time      = rsp_time_q;
    assign rsp_events    = rsp_events_q;
    assign rsp_torn      = rsp_torn_q;
    assign rsp_err       = rsp_err_q;
    assign busy          = (state_q != ST_IDLE);
    // Gated by reset_n so no command is taken while reset is held.
    assign cmd_ready     = reset_n & (state_q == ST_IDLE) & ~rsp_valid_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            step_q          <= RS_HI1;
            sect_q          <= '0;
            retry_q         <= '0;
            tmo_q           <= '0;
            hi1_q           <= '0;
            hi2_q           <= '0;
            lo_q            <= '0;
            ev_q            <= '0;
            avm_address_q   <= '0;
            avm_read_q      <= 1'b0;
            avm_write_q     <= 1'b0;
            avm_writedata_q <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_section_q   <= '0;
            rsp_time_q      <= '0;
            rsp_events_q    <= '0;
            rsp_torn_q      <= 1'b0;
            rsp_err_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        sect_q  <= cmd_section;
                        retry_q <= '0;
                        case (pcu_op_e'(cmd_op))
                            OP_STOP: begin
                                avm_address_q   <= pcu_addr(cmd_section, OFF_LO);
                                avm_writedata_q <= 32'd0;
                                avm_write_q     <= 1'b1;
                                state_q         <= ST_WR;
                            end
                            OP_GO: begin
                                avm_address_q   <= pcu_addr(cmd_section, OFF_HI);
                                avm_writedata_q <= 32'd0;
                                avm_write_q     <= 1'b1;
                                state_q         <= ST_WR;
                            end
                            OP_CLEAR_ALL: begin
                                avm_address_q   <= 4'd0;
                                avm_writedata_q <= 32'd1;
                                avm_write_q     <= 1'b1;
                                state_q         <= ST_WR;
                            end
                            default: begin
                                avm_address_q <= pcu_addr(cmd_section, OFF_HI);
                                avm_read_q    <= 1'b1;
                                step_q        <= RS_HI1;
                                state_q       <= ST_RD_REQ;
                            end
                        endcase
                    end
                end
                ST_WR: begin
                    if (!avm_waitrequest) begin
                        avm_write_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_RD_REQ: begin
                    if (!avm_waitrequest) begin
                        avm_read_q <= 1'b0;
                        tmo_q      <= '0;
                        state_q    <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (avm_readdatavalid) begin
                        case (step_q)
                            RS_HI1: begin
                                hi1_q         <= avm_readdata;
                                avm_address_q <= pcu_addr(sect_q, OFF_LO);
                                avm_read_q    <= 1'b1;
                                step_q        <= RS_LO;
                                state_q       <= ST_RD_REQ;
                            end
                            RS_LO: begin
                                lo_q       <= avm_readdata;
                                avm_read_q <= 1'b1;
                                state_q    <= ST_RD_REQ;
                                // EV is read only on the first pass; retries go straight to HI.
                                if (retry_q == '0) begin
                                    avm_address_q <= pcu_addr(sect_q, OFF_EV);
                                    step_q        <= RS_EV;
                                end else begin
                                    avm_address_q <= pcu_addr(sect_q, OFF_HI);
                                    step_q        <= RS_HI2;
                                end
                            end
                            RS_EV: begin
                                ev_q          <= avm_readdata;
                                avm_address_q <= pcu_addr(sect_q, OFF_HI);
                                avm_read_q    <= 1'b1;
                                step_q        <= RS_HI2;
                                state_q       <= ST_RD_REQ;
                            end
                            RS_HI2: begin
                                hi2_q   <= avm_readdata;
                                state_q <= ST_CHECK;
                            end
                        endcase
                    end else if (tmo_q == TW'(RD_TIMEOUT)) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_section_q <= sect_q;
                        rsp_time_q    <= '0;
                        rsp_events_q  <= '0;
                        rsp_torn_q    <= 1'b0;
                        rsp_err_q     <= 1'b1;
                        state_q       <= ST_RESP;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (hi2_q == hi1_q || retry_q == RW'(MAX_RETRY)) begin
                        // When HI never settled, HI2 pairs with the most recent LO.
                        rsp_valid_q   <= 1'b1;
                        rsp_section_q <= sect_q;
                        rsp_time_q    <= {hi2_q, lo_q};
                        rsp_events_q  <= ev_q;
                        rsp_torn_q    <= (hi2_q != hi1_q);
                        rsp_err_q     <= 1'b0;
                        state_q       <= ST_RESP;
                    end else begin
                        retry_q       <= retry_q + 1'b1;
                        hi1_q         <= hi2_q;
                        avm_address_q <= pcu_addr(sect_q, OFF_LO);
                        avm_read_q    <= 1'b1;
                        step_q        <= RS_LO;
                        state_q       <= ST_RD_REQ;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pcu_sampler_master.sv
// tb/tb_pcu_sampler_master.sv - self-checking bench for pcu_sampler_master
module tb_pcu_sampler_master;
    import pcu_pkg::*;

    localparam int MAX_RETRY  = 3;
    localparam int RD_TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op, cmd_section;
    logic [3:0]  avm_address;
    logic        avm_read, avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_section;
    logic [63:0] rsp_time;
    logic [31:0] rsp_events;
    logic        rsp_torn, rsp_err, busy;

    always #5 clk = ~clk;

    pcu_sampler_master #(.MAX_RETRY(MAX_RETRY), .RD_TIMEOUT(RD_TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_section(cmd_section),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_section(rsp_section),
        .rsp_time(rsp_time), .rsp_events(rsp_events), .rsp_torn(rsp_torn),
        .rsp_err(rsp_err), .busy(busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // PCU slave model: HI/LO reads walk through value lists (last value sticks).
    logic [31:0] hi_vals[$];
    logic [31:0] lo_vals[$];
    logic [31:0] ev_val = 0;
    int hi_n = 0, lo_n = 0;
    bit no_stall = 0, drop_rdv = 0;
    int forced_stall = 0;
    int lat_min = 1, lat_max = 3;
    int pend_cnt = 0;
    logic [31:0] pend_data = 0;
    logic [3:0]  rd_log[$];
    logic [35:0] wr_log[$];
    int req_cycles = 0, stab_err = 0, both_err = 0;
    bit in_req = 0;
    logic [3:0]  last_addr = 0;
    logic [31:0] last_wdata = 0;

    function automatic logic [31:0] hv(input int i);
        if (hi_vals.size() == 0) return 32'd0;
        if (i < hi_vals.size()) return hi_vals[i];
        return hi_vals[hi_vals.size()-1];
    endfunction

    function automatic logic [31:0] lv(input int i);
        if (lo_vals.size() == 0) return 32'd0;
        if (i < lo_vals.size()) return lo_vals[i];
        return lo_vals[lo_vals.size()-1];
    endfunction

    initial begin
        logic [31:0] d;
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = 32'd0;
        forever begin
            @(negedge clk);
            avm_readdatavalid = 1'b0;
            avm_readdata      = $urandom;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = pend_data;
                end
            end
            if (avm_read && avm_write) both_err++;
            if (avm_read || avm_write) begin
                if (in_req && (avm_address != last_addr || (avm_write && avm_writedata != last_wdata)))
                    stab_err++;
                in_req     = 1;
                last_addr  = avm_address;
                last_wdata = avm_writedata;
                req_cycles++;
                if (forced_stall > 0) begin
                    avm_waitrequest = 1'b1;
                    forced_stall--;
                end else if (no_stall) avm_waitrequest = 1'b0;
                else avm_waitrequest = ($urandom_range(0, 2) == 0);
                if (!avm_waitrequest) begin
                    in_req = 0;
                    if (avm_write) wr_log.push_back({avm_address, avm_writedata});
                    else begin
                        rd_log.push_back(avm_address);
                        case (avm_address[1:0])
                            2'd0:    begin d = lv(lo_n); lo_n++; end
                            2'd1:    begin d = hv(hi_n); hi_n++; end
                            2'd2:    d = ev_val;
                            default: d = $urandom;
                        endcase
                        if (!drop_rdv) begin
                            pend_cnt  = $urandom_range(lat_min, lat_max);
                            pend_data = d;
                        end
                    end
                end
            end else begin
                in_req = 0;
                avm_waitrequest = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic send_cmd(input logic [1:0] op, input logic [1:0] sect);
        int n = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_section = sect;
        while (!cmd_ready && n < 3000) begin @(negedge clk); n++; end
        expect_eq("cmd_accept", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] op, input logic [1:0] sect, input int stall, input bit chk_busy);
        logic [3:0]  ea;
        logic [31:0] ed;
        int bc = 0;
        ea = (op == OP_CLEAR_ALL) ? 4'd0 : 4'(int'(sect) * 4 + ((op == OP_GO) ? 1 : 0));
        ed = (op == OP_CLEAR_ALL) ? 32'd1 : 32'd0;
        wr_log.delete(); req_cycles = 0; stab_err = 0;
        if (stall >= 0) forced_stall = stall;
        send_cmd(op, sect);
        while (busy && bc < 200) begin bc++; @(negedge clk); end
        expect_eq("wr_busy_end", 64'(busy), 64'd0);
        expect_eq("wr_count", 64'(wr_log.size()), 64'd1);
        if (wr_log.size() > 0) expect_eq("wr_addr_data", 64'(wr_log[0]), 64'({ea, ed}));
        expect_eq("wr_no_rsp", 64'(rsp_valid), 64'd0);
        expect_eq("wr_stable", 64'(stab_err), 64'd0);
        if (stall >= 0) expect_eq("wr_req_cycles", 64'(req_cycles), 64'(stall + 1));
        if (chk_busy) expect_eq("wr_busy_cycles", 64'(bc), 64'd1);
    endtask

    task automatic do_sample(input logic [1:0] sect);
        logic [3:0]  e_addr[$];
        logic [31:0] h1, h2, lo;
        logic [63:0] t0;
        logic        e_torn;
        int hi_i, lo_i, r, n, hold;
        rd_log.delete(); hi_n = 0; lo_n = 0;
        e_addr = {};
        e_addr.push_back(4'(int'(sect) * 4 + 1));
        e_addr.push_back(4'(int'(sect) * 4 + 0));
        e_addr.push_back(4'(int'(sect) * 4 + 2));
        e_addr.push_back(4'(int'(sect) * 4 + 1));
        h1 = hv(0); lo = lv(0); h2 = hv(1); hi_i = 2; lo_i = 1; r = 0;
        while (h2 != h1 && r < MAX_RETRY) begin
            r++; h1 = h2; lo = lv(lo_i); lo_i++; h2 = hv(hi_i); hi_i++;
            e_addr.push_back(4'(int'(sect) * 4 + 0));
            e_addr.push_back(4'(int'(sect) * 4 + 1));
        end
        e_torn = (h2 != h1);
        send_cmd(OP_SAMPLE, sect);
        n = 0;
        while (!rsp_valid && n < 3000) begin @(negedge clk); n++; end
        expect_eq("rsp_valid", 64'(rsp_valid), 64'd1);
        expect_eq("rsp_time", rsp_time, {h2, lo});
        expect_eq("rsp_events", 64'(rsp_events), 64'(ev_val));
        expect_eq("rsp_torn", 64'(rsp_torn), 64'(e_torn));
        expect_eq("rsp_err", 64'(rsp_err), 64'd0);
        expect_eq("rsp_section", 64'(rsp_section), 64'(sect));
        expect_eq("rd_count", 64'(rd_log.size()), 64'(e_addr.size()));
        for (int i = 0; i < e_addr.size(); i++)
            if (i < rd_log.size()) expect_eq("rd_addr", 64'(rd_log[i]), 64'(e_addr[i]));
        expect_eq("no_cmd_while_rsp", 64'(cmd_ready), 64'd0);
        t0 = rsp_time;
        hold = $urandom_range(0, 3);
        repeat (hold) begin
            @(negedge clk);
            expect_eq("rsp_hold", {rsp_time[62:0], rsp_valid}, {t0[62:0], 1'b1});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        expect_eq("rsp_cleared", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        int n, seen;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_section = 2'd0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        expect_eq("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        expect_eq("rst_busy", 64'(busy), 64'd0);
        expect_eq("rst_avm", {avm_address, avm_read, avm_write, avm_writedata}, 64'd0);
        expect_eq("rst_rsp", {rsp_valid, rsp_torn, rsp_err, rsp_section, rsp_events}, 64'd0);
        expect_eq("rst_time", rsp_time, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        no_stall = 1;
        do_write(OP_GO, 2'd2, 0, 1);
        do_write(OP_CLEAR_ALL, 2'd3, 3, 0);

        hi_vals = '{32'd1}; lo_vals = '{32'h10}; ev_val = 32'd5;
        do_sample(2'd1);
        hi_vals = '{32'd0, 32'd1}; lo_vals = '{32'hFFFF_FFFF, 32'd0}; ev_val = 32'd7;
        do_sample(2'd0);
        hi_vals = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
        lo_vals = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4};
        ev_val = 32'h1234;
        do_sample(2'd3);

        no_stall = 0; lat_min = 1; lat_max = 4;
        for (int it = 0; it < 30; it++) begin
            logic [1:0] s;
            int kind;
            s = 2'($urandom_range(0, 3));
            kind = $urandom_range(0, 4);
            if (kind == 0) do_write(2'($urandom_range(0, 1)) == 2'd0 ? OP_STOP : OP_GO, s, -1, 0);
            else if (kind == 1) do_write(OP_CLEAR_ALL, s, -1, 0);
            else begin
                hi_vals.delete(); lo_vals.delete();
                if (kind == 2) hi_vals.push_back($urandom);
                else if (kind == 3) begin
                    hi_vals.push_back($urandom_range(0, 100));
                    hi_vals.push_back(hi_vals[0] + 1);
                end else
                    for (int k = 0; k < $urandom_range(2, 6); k++) hi_vals.push_back($urandom_range(0, 2));
                for (int k = 0; k < 5; k++) lo_vals.push_back($urandom);
                ev_val = $urandom;
                do_sample(s);
            end
        end

        // Read data never returns: timeout response.
        drop_rdv = 1; rd_log.delete();
        send_cmd(OP_SAMPLE, 2'd2);
        n = 0;
        while (!rsp_valid && n < 3000) begin @(negedge clk); n++; end
        expect_eq("tmo_valid", 64'(rsp_valid), 64'd1);
        expect_eq("tmo_err", 64'(rsp_err), 64'd1);
        expect_eq("tmo_payload", {rsp_time[31:0], rsp_events}, 64'd0);
        expect_eq("tmo_time_hi", 64'(rsp_time[63:32]), 64'd0);
        expect_eq("tmo_reads", 64'(rd_log.size()), 64'd1);
        expect_eq("tmo_latency", 64'(n >= RD_TIMEOUT), 64'd1);
        rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
        drop_rdv = 0;

        // Reset while waiting for read data; the late data must be ignored.
        no_stall = 1; lat_min = 20; lat_max = 20; rd_log.delete(); hi_n = 0; lo_n = 0;
        send_cmd(OP_SAMPLE, 2'd1);
        n = 0;
        while (rd_log.size() == 0 && n < 100) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        expect_eq("midrst_outs", {avm_read, avm_write, rsp_valid, busy, cmd_ready}, 64'd0);
        reset_n = 1'b1;
        seen = 0;
        repeat (30) begin @(negedge clk); if (rsp_valid || busy) seen++; end
        expect_eq("midrst_quiet", 64'(seen), 64'd0);
        lat_min = 1; lat_max = 3;
        hi_vals = '{32'h22}; lo_vals = '{32'h33}; ev_val = 32'h44;
        do_sample(2'd1);

        expect_eq("never_rd_and_wr", 64'(both_err), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
